// File: rtl/vote_recorder.sv
// vote_recorder: single-voter ballot recorder with per-candidate saturating
// tallies and a result-display mode.
//
// Optional feature: define VOTE_TOTAL_EN to add the total_votes output, a
// free-running count of every accepted vote (saturated ones included).
//
// Flow: IDLE --arm--> ARMED --single press--> CONFIRM (LED hold) --> IDLE.
// mode=1 enters RESULT from IDLE or ARMED; from CONFIRM it waits for the
// hold to finish, then goes through IDLE.

module vote_recorder #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int LED_HOLD = 100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode,
    input  logic                          arm_pulse,
    input  logic [NUM_CAND-1:0]           cand_press,
    output logic                          armed_led,
    output logic [NUM_CAND-1:0]           vote_led,
    output logic [CNT_W-1:0]              disp_count,
    output logic [$clog2(NUM_CAND)-1:0]   disp_sel,
    output logic                          sat_flag
`ifdef VOTE_TOTAL_EN
    ,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0] total_votes
`endif
);

    localparam int SEL_W  = $clog2(NUM_CAND);
    // Hold counter only needs to hold LED_HOLD-1; keep at least one bit.
    localparam int HOLD_W = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CONFIRM,
        ST_RESULT
    } state_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic [CNT_W-1:0]    r_tally [NUM_CAND];

    logic                w_single;
    logic [SEL_W-1:0]    w_idx;
    logic [CNT_W-1:0]    w_pick_tally;
    logic [CNT_W-1:0]    w_sel_tally;
    logic                w_pick_max;

    // Decode the candidate buttons: valid only when exactly one bit is set.
    always_comb begin
        w_single = $onehot(cand_press);
        w_idx    = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (cand_press[i]) begin
                w_idx = SEL_W'(i);
            end
        end
    end

    // Tally lookups for the pressed candidate and the displayed candidate.
    always_comb begin
        w_pick_tally = r_tally[w_idx];
        w_sel_tally  = r_tally[disp_sel];
        w_pick_max   = (w_pick_tally == '1);
    end

    // Control FSM with registered outputs and tally storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            armed_led  <= 1'b0;
            vote_led   <= '0;
            disp_count <= '0;
            disp_sel   <= '0;
            sat_flag   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                r_tally[i] <= '0;
            end
`ifdef VOTE_TOTAL_EN
            total_votes <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Arm has priority over a simultaneous press; presses are
                    // never counted here.
                    if (mode) begin
                        r_state    <= ST_RESULT;
                        disp_count <= w_sel_tally;
                    end else if (arm_pulse) begin
                        r_state   <= ST_ARMED;
                        armed_led <= 1'b1;
                    end
                end

                ST_ARMED: begin
                    if (mode) begin
                        // Voter abandoned: nothing is recorded.
                        r_state    <= ST_RESULT;
                        armed_led  <= 1'b0;
                        disp_count <= w_sel_tally;
                    end else if (w_single) begin
                        if (w_pick_max) begin
                            sat_flag <= 1'b1;
                        end else begin
                            r_tally[w_idx] <= w_pick_tally + 1'b1;
                        end
`ifdef VOTE_TOTAL_EN
                        total_votes <= total_votes + 1'b1;
`endif
                        vote_led  <= cand_press;
                        armed_led <= 1'b0;
                        r_hold    <= HOLD_W'(LED_HOLD - 1);
                        r_state   <= ST_CONFIRM;
                    end
                end

                ST_CONFIRM: begin
                    // Counter runs LED_HOLD-1 down to 0, so the LED is lit for
                    // exactly LED_HOLD cycles; mode is not looked at here.
                    if (r_hold == '0) begin
                        r_state  <= ST_IDLE;
                        vote_led <= '0;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end

                ST_RESULT: begin
                    if (!mode) begin
                        r_state    <= ST_IDLE;
                        disp_count <= '0;
                    end else if (w_single) begin
                        disp_sel   <= w_idx;
                        disp_count <= w_pick_tally;
                    end else begin
                        disp_count <= w_sel_tally;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vote_recorder.md
Name: vote_recorder

Overview:
- Consumes the single-cycle valid-press pulses from the per-button debounce stages.
- Arms one voter at a time via an official's arm pulse, accepts exactly one candidate vote, and holds a confirmation LED.
- Keeps per-candidate saturating tallies.
- In result mode, shows the tally of a candidate selected by the candidate buttons.

Parameters:
- NUM_CAND, 4, number of candidate buttons / tally registers (2..8).
- CNT_W, 8, width of each tally register.
- LED_HOLD, 100, clock cycles the confirmation LED stays lit after a vote (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = voting, 1 = result display. Level from a switch, already synchronised.
- arm_pulse  input  1  debounced one-cycle pulse from the official's arm button.
- cand_press  input  NUM_CAND  debounced one-cycle pulses, one bit per candidate button.
- armed_led  output  1  high while a voter is armed.
- vote_led  output  NUM_CAND  one-hot, lit for the candidate just voted during CONFIRM.
- disp_count  output  CNT_W  tally of the selected candidate; 0 outside RESULT.
- disp_sel  output  clog2(NUM_CAND)  index of the candidate being displayed.
- sat_flag  output  1  sticky; set when any tally saturates.

Behaviour:
- One clock; reset is asynchronous and active-high. All state clears immediately on reset assertion.
- Reset values:
  - state = IDLE.
  - All tallies = 0.
  - armed_led = 0, vote_led = 0, disp_count = 0, disp_sel = 0, sat_flag = 0.
  - Hold counter = 0.
- All outputs are registered and change one cycle after the causing input edge.
- "Single press" means cand_press has exactly one bit set (onehot). Zero or multiple bits set = no press.
- FSM states: IDLE, ARMED, CONFIRM, RESULT.
- IDLE:
  - mode=1 -> RESULT.
  - Else arm_pulse=1 -> ARMED; armed_led=1 next cycle.
  - cand_press is ignored.
- ARMED:
  - mode=1 -> RESULT. The voter is abandoned, no tally changes, armed_led clears.
  - Else a single press of bit i -> tally[i] increments.
    - At 2^CNT_W-1 the tally holds and sat_flag is set.
    - vote_led = 1<<i, armed_led = 0, hold counter loads LED_HOLD-1, go to CONFIRM.
  - A multi-bit press is ignored; the state stays ARMED.
  - arm_pulse is ignored.
- CONFIRM:
  - The hold counter decrements each cycle. At 0, go to IDLE and clear vote_led.
  - vote_led is therefore high for exactly LED_HOLD cycles.
  - All presses and arm_pulse are ignored.
  - mode=1 is deferred until CONFIRM completes; a vote is never truncated. The path is IDLE -> RESULT on the next cycle.
- RESULT:
  - A single press of bit i -> disp_sel = i.
  - disp_count is a registered copy of tally[disp_sel], updated every cycle.
  - A multi-bit press is ignored.
  - mode=0 -> IDLE. disp_count is forced to 0 and disp_sel holds its value.
- arm_pulse and cand_press asserted in the same cycle while in IDLE: arm wins, and the press is not counted.
- Tallies and sat_flag clear only on reset.
- Tallies are not externally visible except via disp_count.

Optional Feature:
- Macro: VOTE_TOTAL_EN.
- Defined:
  - Adds output port total_votes, width CNT_W+clog2(NUM_CAND), reset 0.
  - It increments on every accepted vote, including votes whose tally was saturated. It never saturates within its width.
  - In RESULT, total_votes is valid; outside RESULT it still updates.
- Undefined:
  - No port and no extra logic.

Test Plan:
- Reset mid-CONFIRM with defaults: assert reset 1 cycle while vote_led=0001 -> vote_led=0 and armed_led=0 immediately. After release, mode=1 with bit0 pressed -> disp_count=0.
- Normal vote: arm_pulse, then cand_press=0100 -> armed_led 1->0, vote_led=0100 for exactly 100 cycles, then IDLE. RESULT with bit2 pressed -> disp_count=1, disp_sel=2.
- Illegal inputs: cand_press=0100 in IDLE, then arm_pulse, then cand_press=0110 -> no tally change, state stays ARMED. A following cand_press=0010 -> tally[1]=1.
- Saturation with CNT_W=2: four arm+vote cycles on candidate 3 -> tally[3]=3, sat_flag=1 after the 4th vote. With VOTE_TOTAL_EN defined, total_votes=4.
- Mode switching: mode=1 while ARMED -> RESULT with no tally change. mode=1 during CONFIRM -> RESULT entered only after the 100-cycle hold completes.
- Display selection: tallies {2,0,5,1}; in RESULT press bit0, then bit2, then 1010 -> disp_count 2, then 5, then stays 5.
